// File: rtl/jt1943_objdma_buf.sv
// Object DMA front end: copies object RAM into a private dual-port buffer during vblank
// on CPU request, and keeps the pause-screen avatar counter.
module jt1943_objdma_buf #(
    parameter logic [8:0] OBJMAX        = 9'h1FF,
    parameter logic [5:0] AVATAR_FRAMES = 6'd63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen6,
    input  logic       LVBL,
    input  logic       pause,
    output logic [2:0] avatar_idx,
    output logic [8:0] AB,
    input  logic [7:0] DB,
    input  logic       OKOUT,
    output logic       bus_req,
    input  logic       bus_ack,
    output logic       blen,
    input  logic [8:0] pre_scan,
    output logic [7:0] ram_dout
);

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 8;
    localparam int unsigned FW    = 6;
    localparam int unsigned DEPTH = 512;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        REQ,
        COPY,
        FLUSH
    } state_t;

    state_t        state, state_nx;
    logic          req_latch, req_latch_nx, req_clr;
    logic          lvbl_prev, vb_start;
    logic          bus_req_nx, blen_nx;
    logic [AW-1:0] ab_nx, addr_d, addr_d_nx;
    logic [DW-1:0] db_d, db_d_nx;
    logic          wr_pend, wr_pend_nx;
    logic [FW-1:0] frame_cnt;
    logic [DW-1:0] mem [0:DEPTH-1];

    assign vb_start = lvbl_prev & ~LVBL;

    // State register and all cen6-qualified DMA state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_latch <= 1'b0;
            lvbl_prev <= 1'b0;
            bus_req   <= 1'b0;
            blen      <= 1'b0;
            AB        <= '0;
            addr_d    <= '0;
            db_d      <= '0;
            wr_pend   <= 1'b0;
        end else if (cen6) begin
            state     <= state_nx;
            req_latch <= req_latch_nx;
            lvbl_prev <= LVBL;
            bus_req   <= bus_req_nx;
            blen      <= blen_nx;
            AB        <= ab_nx;
            addr_d    <= addr_d_nx;
            db_d      <= db_d_nx;
            wr_pend   <= wr_pend_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx   = state;
        bus_req_nx = bus_req;
        blen_nx    = blen;
        ab_nx      = AB;
        addr_d_nx  = addr_d;
        db_d_nx    = db_d;
        wr_pend_nx = 1'b0;
        req_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (req_latch) state_nx = WAIT_VB;
            end
            WAIT_VB: begin
                if (vb_start && !pause) begin
                    state_nx   = REQ;
                    bus_req_nx = 1'b1;
                    req_clr    = 1'b1;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_nx = COPY;
                    ab_nx    = '0;
                    blen_nx  = 1'b1;
                end
            end
            COPY: begin
                if (bus_ack) begin
                    // Capture the byte for the current address; it lands in the buffer next cen6
                    wr_pend_nx = 1'b1;
                    addr_d_nx  = AB;
                    db_d_nx    = DB;
                    blen_nx    = 1'b1;
                    if (AB == OBJMAX) state_nx = FLUSH;
                    else              ab_nx    = AB + AW'(1);
                end else begin
                    blen_nx = 1'b0;
                end
            end
            FLUSH: begin
                state_nx   = IDLE;
                bus_req_nx = 1'b0;
                blen_nx    = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
        // A new OKOUT always wins so a request during a copy is kept for the next frame
        req_latch_nx = OKOUT | (req_latch & ~req_clr);
    end

    // Buffer write port (no reset: contents survive reset)
    always_ff @(posedge clk) begin
        if (cen6 && wr_pend) mem[addr_d] <= db_d;
    end

    // Buffer read port, free running at clk rate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ram_dout <= '0;
        else        ram_dout <= mem[pre_scan];
    end

    // Pause-screen avatar sequencing, one step every AVATAR_FRAMES+1 vblanks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            avatar_idx <= '0;
        end else if (cen6) begin
            if (!pause) begin
                frame_cnt  <= '0;
                avatar_idx <= '0;
            end else if (vb_start) begin
                if (frame_cnt == AVATAR_FRAMES) begin
                    frame_cnt  <= '0;
                    avatar_idx <= avatar_idx + 3'(1);
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jt1943_objdma_buf.sv
// Bench for jt1943_objdma_buf: transfer-level model checked every cen6 tick,
// buffer readback against the model, and hand-computed anchor values.
module tb_jt1943_objdma_buf;

    logic       clk = 1'b0;
    logic       rst_n, cen6, LVBL, pause, OKOUT, bus_ack;
    logic [2:0] avatar_idx;
    logic [8:0] AB, pre_scan;
    logic [7:0] DB, ram_dout, db_xor;
    logic       bus_req, blen;

    int n_checks = 0;
    int n_errors = 0;
    int req_ticks = 0;
    bit any_req = 1'b0;

    always #5 clk = ~clk;

    // Object RAM stand-in: each byte is its address low byte XOR a per-test key
    assign DB = AB[7:0] ^ db_xor;

    jt1943_objdma_buf dut (
        .clk(clk), .rst_n(rst_n), .cen6(cen6), .LVBL(LVBL), .pause(pause),
        .avatar_idx(avatar_idx), .AB(AB), .DB(DB), .OKOUT(OKOUT),
        .bus_req(bus_req), .bus_ack(bus_ack), .blen(blen),
        .pre_scan(pre_scan), .ram_dout(ram_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer model: what the bus side must look like after each cen6 tick
    localparam int T_IDLE = 0, T_ARMED = 1, T_ASK = 2, T_MOVE = 3, T_DONE = 4;
    int         m_mode, m_frames, m_av, m_waddr;
    logic       m_pending, m_lvbl, m_req, m_blen, m_wpend;
    logic [8:0] m_ab;
    logic [7:0] m_wdata;
    logic [7:0] mbuf [512];
    bit         mvalid [512];

    initial for (int i = 0; i < 512; i++) mvalid[i] = 1'b0;

    always begin
        logic s_cen, s_ok, s_lvbl, s_pause, s_ack;
        logic [7:0] s_x;
        bit vb, taken;
        @(posedge clk);
        s_cen = cen6; s_ok = OKOUT; s_lvbl = LVBL; s_pause = pause; s_ack = bus_ack; s_x = db_xor;
        #1;
        if (!rst_n) begin
            m_mode = T_IDLE; m_pending = 1'b0; m_lvbl = 1'b0; m_req = 1'b0; m_blen = 1'b0;
            m_ab = 9'd0; m_frames = 0; m_av = 0; m_wpend = 1'b0;
        end else if (s_cen) begin
            vb = m_lvbl && !s_lvbl;
            m_lvbl = s_lvbl;
            taken = 1'b0;
            if (!s_pause) begin
                m_frames = 0; m_av = 0;
            end else if (vb) begin
                m_frames++;
                if (m_frames == 64) begin m_frames = 0; m_av = (m_av + 1) % 8; end
            end
            if (m_wpend) begin mbuf[m_waddr] = m_wdata; mvalid[m_waddr] = 1'b1; m_wpend = 1'b0; end
            case (m_mode)
                T_IDLE:  if (m_pending) m_mode = T_ARMED;
                T_ARMED: if (vb && !s_pause) begin m_mode = T_ASK; m_req = 1'b1; taken = 1'b1; end
                T_ASK:   if (s_ack) begin m_mode = T_MOVE; m_ab = 9'd0; m_blen = 1'b1; end
                T_MOVE: begin
                    if (s_ack) begin
                        m_wpend = 1'b1; m_waddr = int'(m_ab); m_wdata = m_ab[7:0] ^ s_x;
                        m_blen = 1'b1;
                        if (m_ab == 9'h1FF) m_mode = T_DONE;
                        else                m_ab = m_ab + 9'd1;
                    end else m_blen = 1'b0;
                end
                default: begin m_mode = T_IDLE; m_req = 1'b0; m_blen = 1'b0; end
            endcase
            if (s_ok) m_pending = 1'b1;
            else if (taken) m_pending = 1'b0;
            chk("bus_req", bus_req, m_req);
            chk("blen", blen, m_blen);
            chk("AB", AB, m_ab);
            chk("avatar_idx", avatar_idx, m_av);
            if (bus_req) begin req_ticks++; any_req = 1'b1; end
        end
    end

    task automatic tick();
        cen6 = 1'b1; @(negedge clk);
        cen6 = 1'b0; @(negedge clk);
    endtask

    task automatic frame();
        LVBL = 1'b1; repeat (4) tick();
        LVBL = 1'b0; repeat (4) tick();
    endtask

    task automatic rd(input int a, input logic [7:0] exp);
        pre_scan = 9'(a);
        @(posedge clk); #1;
        chk($sformatf("ram_dout[%0h]", a), ram_dout, exp);
        @(negedge clk);
    endtask

    task automatic readback_all();
        for (int a = 0; a < 512; a++) begin
            pre_scan = 9'(a);
            @(posedge clk); #1;
            if (mvalid[a]) chk($sformatf("buf[%0h]", a), ram_dout, mbuf[a]);
            @(negedge clk);
        end
    endtask

    task automatic start_copy(input logic [7:0] x, input bit send_ok);
        int guard;
        db_xor = x;
        if (send_ok) begin OKOUT = 1'b1; tick(); OKOUT = 1'b0; end
        LVBL = 1'b1; tick(); tick();
        LVBL = 1'b0;
        guard = 0;
        while (!bus_req && guard < 20) begin tick(); guard++; end
        chk("req_rise", bus_req, 1);
        tick();
        bus_ack = 1'b1;
    endtask

    task automatic do_copy(input logic [7:0] x, input bit send_ok, input int stall_ab, input int ok_ab);
        int guard;
        bit stalled, oked;
        stalled = 1'b0; oked = 1'b0;
        start_copy(x, send_ok);
        guard = 0;
        while (bus_req && guard < 2000) begin
            if (int'(AB) == stall_ab && !stalled) begin
                bus_ack = 1'b0;
                repeat (5) tick();
                chk("stall_ab_hold", AB, 9'(stall_ab));
                chk("stall_blen_low", blen, 0);
                bus_ack = 1'b1;
                stalled = 1'b1;
            end
            if (int'(AB) == ok_ab && !oked) begin OKOUT = 1'b1; oked = 1'b1; end
            if (AB == 9'd200) LVBL = 1'b1;
            tick();
            OKOUT = 1'b0;
            guard++;
        end
        chk("copy_done", bus_req, 0);
        bus_ack = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; cen6 = 1'b0; LVBL = 1'b1; pause = 1'b0; OKOUT = 1'b0;
        bus_ack = 1'b0; pre_scan = 9'd0; db_xor = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_blen", blen, 0);
        chk("rst_AB", AB, 0);
        chk("rst_avatar", avatar_idx, 0);
        chk("rst_ram_dout", ram_dout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // vblanks without a request leave the bus alone
        frame(); frame();
        chk("noreq_bus_req", bus_req, 0);
        chk("noreq_any", any_req, 0);

        // basic copy, ack two cen after the request
        req_ticks = 0;
        do_copy(8'h00, 1'b1, -1, -1);
        chk("basic_req_ticks", req_ticks, 515);
        rd(9'h0A5, 8'hA5);
        rd(9'h000, 8'h00);
        rd(9'h1FF, 8'hFF);
        readback_all();

        // stalled copy with a new request arriving mid-transfer, then the re-armed copy
        req_ticks = 0;
        do_copy(8'h3C, 1'b1, 100, 250);
        chk("stall_req_ticks", req_ticks, 520);
        rd(9'h064, 8'h58);
        rd(9'h065, 8'h59);
        readback_all();
        do_copy(8'h77, 1'b0, -1, -1);
        rd(9'h064, 8'h13);
        readback_all();

        // reset in the middle of a copy
        start_copy(8'h5A, 1'b1);
        guard = 0;
        while (AB != 9'd300 && guard < 1000) begin tick(); guard++; end
        chk("reached_ab300", AB, 300);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_bus_req", bus_req, 0);
        chk("async_blen", blen, 0);
        chk("async_AB", AB, 0);
        bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        any_req = 1'b0;
        frame();
        chk("post_rst_idle", any_req, 0);
        rd(9'd298, 8'h70);
        rd(9'd299, 8'h5C);
        rd(9'd0, 8'h5A);
        readback_all();

        // pause holds a pending request and steps the avatar
        pause = 1'b1;
        OKOUT = 1'b1; tick(); OKOUT = 1'b0;
        any_req = 1'b0;
        repeat (130) frame();
        chk("pause_no_req", any_req, 0);
        chk("pause_avatar", avatar_idx, 2);
        pause = 1'b0;
        tick();
        chk("unpause_avatar", avatar_idx, 0);
        do_copy(8'h11, 1'b0, -1, -1);
        rd(9'h1FF, 8'hEE);
        readback_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
